// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and radix-2 Booth recoding.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

    typedef enum logic [1:0] {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB} booth_op_t;

    // {P_lo[0], q_-1}: 01 starts a run of zeros (add), 10 starts a run of ones (subtract).
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        case (pair)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_radix2_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into P_hi, then an
// arithmetic right shift of the whole {P_hi, P_lo, q_-1} register.
module booth_radix2_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [2*WIDTH+1:0] acc,
    input  logic signed [WIDTH-1:0]   a,
    output logic signed [2*WIDTH+1:0] acc_next
);

    logic signed [WIDTH:0] hi;
    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] hi_sum;

    assign hi    = acc[2*WIDTH+1:WIDTH+1];
    assign a_ext = {a[WIDTH-1], a};

    always_comb begin
        hi_sum = hi;
        case (booth_decode(acc[1:0]))
            BOOTH_ADD: hi_sum = hi + a_ext;
            BOOTH_SUB: hi_sum = hi - a_ext;
            default:   hi_sum = hi;
        endcase
    end

    // P_hi carries one guard bit, so negating -2^(W-1) stays representable before the shift.
    assign acc_next = $signed({hi_sum, acc[WIDTH:0]}) >>> 1;

endmodule

// File: rtl/booth_signed_multiplier_seq.sv
// Multi-cycle signed WIDTH x WIDTH multiplier, one Booth partial product per clock,
// with valid/ready handshakes on operand and product sides.
module booth_signed_multiplier_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    mult_state_t               state;
    logic [CNT_W-1:0]          cnt;
    logic                      loaded;
    logic signed [WIDTH-1:0]   a_q;
    logic signed [WIDTH-1:0]   b_q;
    logic signed [2*WIDTH+1:0] acc;
    logic signed [2*WIDTH+1:0] acc_next;

    booth_radix2_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .a        (a_q),
        .acc_next (acc_next)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // The first BUSY cycle only seeds the datapath from the captured multiplier; the
    // WIDTH Booth steps follow, giving WIDTH+1 clocks from accept to out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            loaded  <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= A;
                        b_q    <= B;
                        cnt    <= CNT_W'(WIDTH - 1);
                        loaded <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (!loaded) begin
                        acc    <= {{(WIDTH + 1){1'b0}}, b_q, 1'b0};
                        loaded <= 1'b1;
                    end else begin
                        acc <= acc_next;
                        if (cnt == '0) begin
                            product <= acc_next[2*WIDTH:1];
                            state   <= DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
